// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared encodings for the memory-side responder: access size codes,
//   FSM state encoding and a saturating-increment helper for the optional
//   statistics counters (enabled by the MEM_RESP_STATS_EN macro).
package mem_resp_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mem_resp_lane_ctl.sv
// mem_resp_lane_ctl
//   Combinational byte-lane steering for a store.
//   Ports:
//     addr_lo  in  2   latched addr[1:0]
//     size     in  2   00 word, 01 half, 10 byte, 11 treated as word
//     wdata    in  32  right-justified store data
//     byte_en  out 4   lanes to write (all zero when misaligned)
//     wword    out 32  store data replicated onto every candidate lane
//     misalign out 1   word with addr_lo!=0, or half with addr_lo[0]!=0
module mem_resp_lane_ctl
    import mem_resp_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic        misalign
);

    always_comb begin
        byte_en  = 4'b1111;
        wword    = wdata;
        misalign = 1'b0;
        case (size)
            SZ_HALF: begin
                misalign = addr_lo[0];
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                wword   = {4{wdata[7:0]}};
            end
            default: begin
                // SZ_WORD and the reserved code both behave as a word access.
                misalign = |addr_lo;
            end
        endcase
        // A misaligned access must never touch storage.
        if (misalign) begin
            byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Target end of the CPU memory port. Accepts one access at a time,
//   inserts WAIT_CYCLES wait states, then completes with a one-cycle ack.
//   Optional statistics counters are built when MEM_RESP_STATS_EN is defined.
//
//   Handshake: req is sampled only in IDLE; a high req at a rising edge
//   accepts the request and latches wr/addr/size/wdata. busy is high from the
//   cycle after accept through the ack cycle inclusive; ack is a single-cycle
//   pulse and rdata/misalign are meaningful only while ack=1 (otherwise 0).
//
//   Ports:
//     clk       in   system clock, rising edge
//     reset     in   asynchronous active-low reset
//     req       in   request strobe
//     wr        in   1 = write, 0 = read
//     addr      in   32-bit byte address (bits above ADDR_W ignored)
//     size      in   access size code
//     wdata     in   right-justified store data
//     busy      out  transaction in flight
//     ack       out  completion pulse
//     rdata     out  aligned word for reads
//     misalign  out  misaligned access flag
//     rd_count / wr_count / err_count  out  (MEM_RESP_STATS_EN only)
//     dbg_state out  current FSM state
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        misalign,
`ifdef MEM_RESP_STATS_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count,
`endif
    output logic [1:0]  dbg_state
);

    localparam int WORDS = 2 ** (ADDR_W - 2);

    state_t              state, next_state;
    logic [3:0]          cnt;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic [31:0]         wdata_q;
    logic [31:0]         mem [WORDS];

    logic [3:0]          byte_en;
    logic [31:0]         wword;
    logic                mis_raw;
    logic                addr_hi_unused;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign addr_hi_unused = ^addr[31:ADDR_W];

    mem_resp_lane_ctl u_lane_ctl (
        .addr_lo  (addr_q[1:0]),
        .size     (size_q),
        .wdata    (wdata_q),
        .byte_en  (byte_en),
        .wword    (wword),
        .misalign (mis_raw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= SZ_WORD;
            wdata_q <= 32'd0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req) begin
                cnt     <= 4'(WAIT_CYCLES);
                wr_q    <= wr;
                addr_q  <= addr[ADDR_W-1:0];
                size_q  <= size;
                wdata_q <= wdata;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req) next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (cnt == 4'd1) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Storage is intentionally not reset. Reset forces IDLE asynchronously,
    // so an aborted write can never reach this enable.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[addr_q[ADDR_W-1:2]][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        ack      = (state == ST_RESP);
        misalign = ack && mis_raw;
        rdata    = 32'd0;
        if (ack && !wr_q && !mis_raw) begin
            rdata = mem[addr_q[ADDR_W-1:2]];
        end
    end

    assign dbg_state = state;

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count  <= 16'd0;
            wr_count  <= 16'd0;
            err_count <= 16'd0;
        end else if (state == ST_RESP) begin
            if (!wr_q)            rd_count  <= sat_inc(rd_count);
            if (wr_q && !mis_raw) wr_count  <= sat_inc(wr_count);
            if (mis_raw)          err_count <= sat_inc(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder. Two instances share clock, reset and
//   request fields: u_dut1 (WAIT_CYCLES=1) for the functional sequence and
//   u_dut0 (WAIT_CYCLES=0) for back-to-back issue with req held high.
module tb_mem_responder;
    import mem_resp_pkg::*;

    logic        clk;
    logic        reset;
    logic        req1, req0;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;

    logic        busy1, ack1, misalign1;
    logic [31:0] rdata1;
    logic [1:0]  dbg_state1;
    logic        busy0, ack0, misalign0;
    logic [31:0] rdata0;
    logic [1:0]  dbg_state0;
`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_count1, wr_count1, err_count1;
    logic [15:0] rd_count0, wr_count0, err_count0;
`endif

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .wr(wr), .addr(addr), .size(size),
        .wdata(wdata), .busy(busy1), .ack(ack1), .rdata(rdata1), .misalign(misalign1),
`ifdef MEM_RESP_STATS_EN
        .rd_count(rd_count1), .wr_count(wr_count1), .err_count(err_count1),
`endif
        .dbg_state(dbg_state1)
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .wr(wr), .addr(addr), .size(size),
        .wdata(wdata), .busy(busy0), .ack(ack0), .rdata(rdata0), .misalign(misalign0),
`ifdef MEM_RESP_STATS_EN
        .rd_count(rd_count0), .wr_count(wr_count0), .err_count(err_count0),
`endif
        .dbg_state(dbg_state0)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks (u_dut1) ----------------
    // Issues one request, then waits (bounded) for ack. lat counts falling
    // edges after the accept edge up to the first one where ack is seen;
    // lat=0 means no ack arrived within the budget.
    task automatic txn(input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] rd, output logic mis, output logic bsy_first);
        lat = 0;
        rd  = 32'd0;
        mis = 1'b0;
        @(negedge clk);
        req1 = 1'b1; wr = w; addr = a; size = s; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        bsy_first = busy1;
        for (int n = 1; n <= 20; n++) begin
            if (ack1) begin
                lat = n;
                rd  = rdata1;
                mis = misalign1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_txn(input string tag, input logic w, input logic [31:0] a,
                          input logic [1:0] s, input logic [31:0] d,
                          input logic exp_mis, input logic chk_rd, input logic [31:0] exp_rd);
        int          lat;
        logic [31:0] rd;
        logic        mis, bsy;
        txn(w, a, s, d, lat, rd, mis, bsy);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_misalign"}, {31'd0, mis}, {31'd0, exp_mis});
        if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          lat;
        logic [31:0] rd;
        logic        mis, bsy;
        logic [9:0]  ack_vec, busy_vec;

        reset = 1'b0; req1 = 1'b0; req0 = 1'b0;
        wr = 1'b0; addr = 32'd0; size = SZ_WORD; wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_ack", {31'd0, ack1}, 32'd0);
        check("rst_rdata", rdata1, 32'd0);
        check("rst_misalign", {31'd0, misalign1}, 32'd0);
        check("rst_state", {30'd0, dbg_state1}, {30'd0, ST_IDLE});
        reset = 1'b1;

        // Word write, then read back; busy must be up in the cycle after accept.
        txn(1'b1, 32'h10, SZ_WORD, 32'hDEADBEEF, lat, rd, mis, bsy);
        check("wr_word_latency", 32'(lat), 32'd2);
        check("wr_word_misalign", {31'd0, mis}, 32'd0);
        check("busy_after_accept", {31'd0, bsy}, 32'd1);
        do_txn("rd_word", 1'b0, 32'h10, SZ_WORD, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

        // Byte write into lane 2.
        do_txn("wr_byte", 1'b1, 32'h12, SZ_BYTE, 32'h000000AA, 1'b0, 1'b0, 32'h0);
        do_txn("rd_after_byte", 1'b0, 32'h10, SZ_WORD, 32'h0, 1'b0, 1'b1, 32'hDEAABEEF);

        // Misaligned half write leaves storage untouched.
        do_txn("wr_half_mis", 1'b1, 32'h13, SZ_HALF, 32'h00001234, 1'b1, 1'b0, 32'h0);
        do_txn("rd_after_mis", 1'b0, 32'h10, SZ_WORD, 32'h0, 1'b0, 1'b1, 32'hDEAABEEF);

        // Misaligned word read returns zero data.
        do_txn("rd_word_mis", 1'b0, 32'h11, SZ_WORD, 32'h0, 1'b1, 1'b1, 32'h0);

        // Aligned half write to the upper half; upper wdata bits are ignored.
        do_txn("wr_zero_24", 1'b1, 32'h24, SZ_WORD, 32'h0, 1'b0, 1'b0, 32'h0);
        do_txn("wr_half_hi", 1'b1, 32'h26, SZ_HALF, 32'hFFFFABCD, 1'b0, 1'b0, 32'h0);
        do_txn("rd_after_half", 1'b0, 32'h24, SZ_WORD, 32'h0, 1'b0, 1'b1, 32'hABCD0000);

        // Reset in the middle of a write's wait state aborts it.
        do_txn("wr_zero_20", 1'b1, 32'h20, SZ_WORD, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        req1 = 1'b1; wr = 1'b1; addr = 32'h20; size = SZ_WORD; wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        check("abort_in_wait", {30'd0, dbg_state1}, {30'd0, ST_WAIT});
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_ack", {31'd0, ack1}, 32'd0);
        check("abort_rdata", rdata1, 32'd0);
        check("abort_misalign", {31'd0, misalign1}, 32'd0);
        check("abort_state", {30'd0, dbg_state1}, {30'd0, ST_IDLE});
`ifdef MEM_RESP_STATS_EN
        check("abort_rd_count", {16'd0, rd_count1}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        do_txn("rd_after_abort", 1'b0, 32'h20, SZ_WORD, 32'h0, 1'b0, 1'b1, 32'h0);

        // Address wrap: 0x104 aliases byte offset 4 with 256 bytes of storage.
        do_txn("wr_wrap", 1'b1, 32'h104, SZ_WORD, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        do_txn("rd_wrap", 1'b0, 32'h4, SZ_WORD, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);

        do_txn("wr_word_08", 1'b1, 32'h8, SZ_WORD, 32'h55AA55AA, 1'b0, 1'b0, 32'h0);
        do_txn("wr_half_mis09", 1'b1, 32'h9, SZ_HALF, 32'h0000FFFF, 1'b1, 1'b0, 32'h0);
        do_txn("rd_word_08", 1'b0, 32'h8, SZ_WORD, 32'h0, 1'b0, 1'b1, 32'h55AA55AA);

`ifdef MEM_RESP_STATS_EN
        // Since the last reset: 3 reads, 2 completed writes, 1 misaligned write.
        check("stat_rd_count", {16'd0, rd_count1}, 32'd3);
        check("stat_wr_count", {16'd0, wr_count1}, 32'd2);
        check("stat_err_count", {16'd0, err_count1}, 32'd1);
`endif

        // Back-to-back with WAIT_CYCLES=0 and req held high for 10 cycles:
        // RESP and IDLE alternate, so ack and busy both follow 1,0,1,0,...
        @(negedge clk);
        req0 = 1'b1; wr = 1'b0; addr = 32'h0; size = SZ_WORD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ack_vec[i]  = ack0;
            busy_vec[i] = busy0;
        end
        req0 = 1'b0;
        check("b2b_ack_pattern", {22'd0, ack_vec}, {22'd0, 10'b0101010101});
        check("b2b_busy_pattern", {22'd0, busy_vec}, {22'd0, 10'b0101010101});
        repeat (3) @(negedge clk);
        check("b2b_drained", {30'd0, dbg_state0}, {30'd0, ST_IDLE});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
